sobel_frame_ctrl: RTL and testbench
===================================

Name: sobel_frame_ctrl

Overview:
- Frame-scan sequencer for the Sobel edge datapath (dut_core).
- Accepts a raster pixel stream with a valid/ready handshake and advances the 3x3 window/line buffers (win_shift) on each accepted pixel.
- Tracks column/row position, drives dut_core's on_edge with the correct pipeline alignment, and marks which dut_core outputs are valid.
- Sits between the pixel source / line buffers and dut_core; software-style start/busy/done control per frame.

Parameters:
- WIDTH, 16, bit width of the column/row counters and the frame-size configuration.
- LATENCY, 2, dut_core cycles from window accept to pixel_out; must be >= 1.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request to begin a frame.
- width_cfg  in  WIDTH  frame columns; sampled at accepted start.
- height_cfg  in  WIDTH  frame rows; sampled at accepted start.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at frame completion.
- cfg_err  out  1  one-cycle pulse when a start is rejected.
- pix_valid  in  1  source has a pixel.
- pix_ready  out  1  controller accepts a pixel.
- win_shift  out  1  advance line buffers/window; equals pix_valid & pix_ready.
- col  out  WIDTH  column of the pixel accepted this cycle.
- row  out  WIDTH  row of the pixel accepted this cycle.
- on_edge  out  1  to dut_core.on_edge.
- out_valid  out  1  dut_core.pixel_out holds a valid result this cycle.
- out_last  out  1  out_valid for the final pixel of the frame.

Behaviour:
- Reset: asynchronous. State goes to IDLE. All outputs, counters, latched config, the on_edge register and the valid pipeline clear to 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - pix_ready = 0.
  - start with width_cfg >= 3 and height_cfg >= 3: latch W and H, col = row = 0, go to RUN.
  - start with either value < 3: cfg_err = 1 for one cycle, stay in IDLE.
- RUN:
  - pix_ready = 1.
  - On accept: if col == W-1, then col = 0 and row += 1; else col += 1.
  - Accept of pixel (W-1, H-1) goes to DRAIN; pix_ready is 0 from the next cycle.
- DRAIN:
  - pix_ready = 0.
  - Leave for DONE in the cycle out_last = 1.
- DONE:
  - done = 1 for exactly one cycle, i.e. the cycle after out_last.
  - Next state is IDLE. A start in that IDLE cycle is accepted.
- start while busy or in DONE: ignored. cfg_err pulses for one cycle; the frame in progress is unaffected.
- Edge flag for the accepted pixel: col == 0 or col == W-1 or row == 0 or row == H-1.
- on_edge alignment:
  - Registered, delayed LATENCY-1 cycles from the accept, so with LATENCY = 2 it is visible in cycle t+1 for an accept in cycle t.
  - This matches dut_core's second register stage.
  - Cycles with no accept propagate 0.
- Valid pipeline:
  - LATENCY-deep shift register, shifted every cycle.
  - Input is the win_shift signal; out_valid is the final stage.
  - An accept in cycle t gives out_valid in cycle t+LATENCY. Input gaps are reproduced exactly.
  - A parallel stage carries the last-pixel flag to drive out_last.
- No backpressure from downstream: dut_core free-runs, and consumers must take pixel_out whenever out_valid = 1.
- Counters compare against the latched W and H only; a config change mid-frame has no effect.
- Reset mid-frame:
  - Immediate abort. The pipeline is flushed, so no out_valid or done follows.
  - Line-buffer contents are the owner's responsibility.

Test Plan:
1. W=4, H=3, pix_valid held 1, first accept at cycle 0:
   - 12 win_shift pulses in cycles 0–11.
   - out_valid in cycles 2–13; out_last at cycle 13; done at cycle 14 only.
   - on_edge = 0 only for the pixels at (1,1) and (2,1), i.e. accepts 5 and 6, seen as on_edge low in cycles 6 and 7.
2. W=3, H=3, pix_valid pattern 1,0,1,1,0,...:
   - col/row advance only on accepts; wrap to col 0 / row+1 after col 2.
   - out_valid repeats the accept pattern delayed by 2 cycles.
   - Only the centre pixel (1,1) has on_edge = 0.
3. Start with width_cfg = 2, height_cfg = 5 -> cfg_err for one cycle, busy stays 0, pix_ready stays 0.
4. Start during RUN with different config -> cfg_err pulse; the original frame completes with its original W and H and the normal done.
5. Reset asserted mid-RUN after 5 accepts -> all outputs 0 in the same cycle without waiting for a clock edge, and no later out_valid or done. A fresh start then scans a full frame from (0,0).
6. Back-to-back frames: start in the cycle done = 1 is rejected with cfg_err; start one cycle later begins the second frame with col = row = 0 and a correct out_valid count.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_frame_ctrl
//
// Frame-scan sequencer for the Sobel edge datapath (dut_core). It accepts a
// raster pixel stream, advances the 3x3 window / line buffers on every accepted
// pixel, tracks the column/row of that pixel, and produces dut_core's on_edge
// input plus out_valid/out_last markers aligned to dut_core's output.
//
// Handshake: a pixel transfers in any cycle where pix_valid and pix_ready are
// both 1 (win_shift = pix_valid & pix_ready). pix_valid may rise or fall at any
// time; pix_ready depends only on controller state, never on pix_valid. There
// is no downstream backpressure: whenever out_valid = 1 the consumer must take
// dut_core.pixel_out in that cycle.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   start                  one-cycle frame request (accepted only in IDLE)
//   width_cfg, height_cfg  frame size, latched when start is accepted (>= 3)
//   busy                   high in RUN and DRAIN
//   done                   one-cycle pulse, the cycle after out_last
//   cfg_err                one-cycle pulse, the cycle after a rejected start
//   pix_valid / pix_ready  pixel stream handshake
//   win_shift              advance window/line buffers (pixel accepted)
//   col, row               position of the pixel accepted this cycle
//   on_edge                to dut_core.on_edge, delayed LATENCY-1 cycles
//   out_valid, out_last    dut_core.pixel_out valid / final pixel of frame
//   state_dbg              current FSM state (00 IDLE, 01 RUN, 10 DRAIN, 11 DONE)
// -----------------------------------------------------------------------------
module sobel_frame_ctrl #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] width_cfg,
  input  logic [WIDTH-1:0] height_cfg,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             win_shift,
  output logic [WIDTH-1:0] col,
  output logic [WIDTH-1:0] row,
  output logic             on_edge,
  output logic             out_valid,
  output logic             out_last,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_DIM = WIDTH'(3);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] h_q;
  logic [WIDTH-1:0] col_q;
  logic [WIDTH-1:0] row_q;
  logic             cfg_err_q;
  logic             cfg_ok;
  logic             start_ok;
  logic             accept;
  logic             col_at_end;
  logic             row_at_end;
  logic             is_last;
  logic             edge_flag;
  logic [LATENCY-1:0] vld_pipe;
  logic [LATENCY-1:0] last_pipe;

  assign cfg_ok     = (width_cfg >= MIN_DIM) && (height_cfg >= MIN_DIM);
  assign start_ok   = (state_q == S_IDLE) && start && cfg_ok;
  assign accept     = pix_valid && pix_ready;
  assign col_at_end = (col_q == w_q - ONE);
  assign row_at_end = (row_q == h_q - ONE);
  assign is_last    = col_at_end && row_at_end;
  assign edge_flag  = (col_q == '0) || col_at_end || (row_q == '0) || row_at_end;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (accept && is_last) state_d = S_DRAIN;
      // The final result leaves dut_core in the out_last cycle, so DONE
      // follows it directly.
      S_DRAIN: if (out_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_RUN: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign win_shift = accept;
  assign col       = col_q;
  assign row       = row_q;
  assign cfg_err   = cfg_err_q;
  assign state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // Frame configuration, scan position and start rejection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      if (start_ok) begin
        w_q   <= width_cfg;
        h_q   <= height_cfg;
        col_q <= '0;
        row_q <= '0;
      end else if (accept) begin
        if (col_at_end) begin
          col_q <= '0;
          // Parking the position at (0,0) after the last pixel keeps col/row
          // quiet through DRAIN/DONE/IDLE.
          row_q <= is_last ? '0 : row_q + ONE;
        end else begin
          col_q <= col_q + ONE;
        end
      end
      // Any start that does not launch a frame is rejected: bad size in IDLE,
      // or a frame already in flight (RUN, DRAIN, DONE).
      cfg_err_q <= start && !start_ok;
    end
  end

  // ---------------------------------------------------------------------------
  // Valid / last pipeline: shifted every cycle so input gaps reappear exactly
  // LATENCY cycles later, matching dut_core's free-running pipeline.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= accept;
      last_pipe[0] <= accept && is_last;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[LATENCY-1];
  assign out_last  = last_pipe[LATENCY-1];

  // ---------------------------------------------------------------------------
  // on_edge: dut_core samples on_edge one stage before pixel_out, so the flag
  // is delayed LATENCY-1 cycles. Non-accept cycles carry 0.
  // ---------------------------------------------------------------------------
  generate
    if (LATENCY == 1) begin : g_edge_comb
      assign on_edge = accept && edge_flag;
    end else begin : g_edge_pipe
      logic [LATENCY-2:0] edge_pipe;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          edge_pipe <= '0;
        end else begin
          edge_pipe[0] <= accept && edge_flag;
          for (int i = 1; i < LATENCY - 1; i++) begin
            edge_pipe[i] <= edge_pipe[i-1];
          end
        end
      end
      assign on_edge = edge_pipe[LATENCY-2];
    end
  endgenerate

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sobel_frame_ctrl
//
// Directed bench for sobel_frame_ctrl (WIDTH = 16, LATENCY = 2). Inputs are
// driven 1 time unit after the rising edge; outputs are sampled on the falling
// edge. Cycle 0 of a frame is the first RUN cycle (the cycle after start).
// -----------------------------------------------------------------------------
module tb_sobel_frame_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] width_cfg;
  logic [15:0] height_cfg;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic        pix_valid;
  logic        pix_ready;
  logic        win_shift;
  logic [15:0] col;
  logic [15:0] row;
  logic        on_edge;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int done_cyc;
  int last_cyc;
  int n_valid;
  int n_inner;
  int first_valid;

  sobel_frame_ctrl #(.WIDTH(16), .LATENCY(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .width_cfg  (width_cfg),
    .height_cfg (height_cfg),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win_shift  (win_shift),
    .col        (col),
    .row        (row),
    .on_edge    (on_edge),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Check helper
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver + timeline model for one frame. Called one unit after a rising edge
  // with the DUT in IDLE. gaps selects the pix_valid pattern 1,0,1,1,0 repeated.
  // mid_start pulses a different-size start in frame cycle 3. restart drives a
  // start in the DONE cycle. err_at_start is the cfg_err value expected in the
  // cycle the frame's start is driven.
  // ---------------------------------------------------------------------------
  task automatic run_frame(input int w, input int h, input bit gaps,
                           input bit mid_start, input bit restart,
                           input bit err_at_start,
                           output int o_done, output int o_last,
                           output int o_valid, output int o_inner,
                           output int o_first);
    bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit acc_h  [64];
    bit edge_h [64];
    bit last_h [64];
    int total = w * h;
    int cnt   = 0;
    int lc    = -1;
    bit pv;
    bit acc;
    bit exp_ov;
    bit exp_ol;
    bit exp_oe;
    int pc;
    int pr;
    o_done  = -1;
    o_last  = -1;
    o_valid = 0;
    o_inner = 0;
    o_first = -1;

    start      = 1'b1;
    width_cfg  = 16'(w);
    height_cfg = 16'(h);
    pix_valid  = 1'b0;
    @(negedge clock);
    chk("start_cycle_cfg_err", cfg_err, err_at_start);
    chk("start_cycle_busy", busy, 0);
    chk("start_cycle_state", state_dbg, 0);
    tick();

    for (int c = 0; c < 64; c++) begin
      pv = gaps ? pat[c % 5] : 1'b1;
      start = 1'b0;
      if (mid_start && c == 3) begin
        start      = 1'b1;
        width_cfg  = 16'd5;
        height_cfg = 16'd6;
      end
      if (restart && lc >= 0 && c == lc + 3) begin
        start      = 1'b1;
        width_cfg  = 16'd3;
        height_cfg = 16'd3;
      end
      pix_valid = pv;
      @(negedge clock);

      acc = (cnt < total) && pv;
      chk("win_shift", win_shift, acc);
      chk("pix_ready", pix_ready, cnt < total);
      acc_h[c]  = acc;
      edge_h[c] = 1'b0;
      last_h[c] = 1'b0;
      if (acc) begin
        pc = cnt % w;
        pr = cnt / w;
        chk("col", col, pc);
        chk("row", row, pr);
        edge_h[c] = (pc == 0) || (pc == w - 1) || (pr == 0) || (pr == h - 1);
        last_h[c] = (cnt == total - 1);
        if (last_h[c]) lc = c;
        cnt++;
      end

      exp_ov = (c >= 2) ? acc_h[c-2] : 1'b0;
      exp_ol = (c >= 2) ? last_h[c-2] : 1'b0;
      exp_oe = (c >= 1) ? (acc_h[c-1] && edge_h[c-1]) : 1'b0;
      chk("out_valid", out_valid, exp_ov);
      chk("out_last", out_last, exp_ol);
      chk("on_edge", on_edge, exp_oe);
      chk("busy", busy, (lc < 0) || (c <= lc + 2));
      chk("done", done, (lc >= 0) && (c == lc + 3));
      chk("cfg_err", cfg_err, mid_start && (c == 4));

      if (out_valid) begin
        o_valid++;
        if (o_first < 0) o_first = c;
      end
      if (out_last && o_last < 0) o_last = c;
      if (done && o_done < 0) o_done = c;
      if (c >= 1 && acc_h[c-1] && !on_edge) o_inner++;

      tick();
      if (lc >= 0 && c == lc + 3) break;
    end
    if (!restart) start = 1'b0;
    pix_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    pix_valid  = 1'b0;
    width_cfg  = 16'd0;
    height_cfg = 16'd0;
    tick();
    tick();
    @(negedge clock);
    chk("rst_state", state_dbg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_on_edge", on_edge, 0);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    tick();
    reset = 1'b0;
    tick();

    // 1: 4x3 frame, pix_valid held high
    run_frame(4, 3, 1'b0, 1'b0, 1'b0, 1'b0, done_cyc, last_cyc, n_valid, n_inner, first_valid);
    chk("t1_done_cycle", done_cyc, 14);
    chk("t1_last_cycle", last_cyc, 13);
    chk("t1_first_valid", first_valid, 2);
    chk("t1_valid_count", n_valid, 12);
    chk("t1_inner_count", n_inner, 2);
    tick();

    // 2: 3x3 frame, pix_valid pattern 1,0,1,1,0 (accepts 0,2,3,5,7,8,10,12,13)
    run_frame(3, 3, 1'b1, 1'b0, 1'b0, 1'b0, done_cyc, last_cyc, n_valid, n_inner, first_valid);
    chk("t2_done_cycle", done_cyc, 16);
    chk("t2_last_cycle", last_cyc, 15);
    chk("t2_valid_count", n_valid, 9);
    chk("t2_inner_count", n_inner, 1);
    tick();

    // 3: rejected starts (width too small, then height too small)
    start = 1'b1; width_cfg = 16'd2; height_cfg = 16'd5; pix_valid = 1'b1;
    @(negedge clock);
    chk("t3_err_same_cycle", cfg_err, 0);
    tick();
    start = 1'b0;
    @(negedge clock);
    chk("t3_err_pulse", cfg_err, 1);
    chk("t3_busy", busy, 0);
    chk("t3_pix_ready", pix_ready, 0);
    chk("t3_win_shift", win_shift, 0);
    chk("t3_state", state_dbg, 0);
    tick();
    @(negedge clock);
    chk("t3_err_one_cycle", cfg_err, 0);
    chk("t3_busy_after", busy, 0);
    tick();
    start = 1'b1; width_cfg = 16'd3; height_cfg = 16'd2;
    tick();
    start = 1'b0;
    @(negedge clock);
    chk("t3_err_height", cfg_err, 1);
    chk("t3_state_height", state_dbg, 0);
    tick();
    pix_valid = 1'b0;
    tick();

    // 4: start during RUN with a different size is ignored
    run_frame(4, 3, 1'b0, 1'b1, 1'b0, 1'b0, done_cyc, last_cyc, n_valid, n_inner, first_valid);
    chk("t4_done_cycle", done_cyc, 14);
    chk("t4_valid_count", n_valid, 12);
    tick();

    // 5: asynchronous reset after 5 accepts
    start = 1'b1; width_cfg = 16'd4; height_cfg = 16'd3;
    tick();
    start = 1'b0; pix_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("t5_pre_out_valid", out_valid, 1);
    chk("t5_pre_col", col, 1);
    chk("t5_pre_row", row, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_rst_state", state_dbg, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_pix_ready", pix_ready, 0);
    chk("t5_rst_win_shift", win_shift, 0);
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_out_last", out_last, 0);
    chk("t5_rst_on_edge", on_edge, 0);
    chk("t5_rst_col", col, 0);
    chk("t5_rst_row", row, 0);
    chk("t5_rst_done", done, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("t5_quiet_out_valid", out_valid, 0);
      chk("t5_quiet_done", done, 0);
      chk("t5_quiet_busy", busy, 0);
      tick();
    end
    run_frame(3, 3, 1'b0, 1'b0, 1'b0, 1'b0, done_cyc, last_cyc, n_valid, n_inner, first_valid);
    chk("t5_fresh_done_cycle", done_cyc, 11);
    chk("t5_fresh_valid_count", n_valid, 9);
    chk("t5_fresh_inner_count", n_inner, 1);
    tick();

    // 6: back-to-back frames; start in the DONE cycle is rejected, one cycle
    // later the second frame is accepted
    run_frame(4, 3, 1'b0, 1'b0, 1'b1, 1'b0, done_cyc, last_cyc, n_valid, n_inner, first_valid);
    chk("t6a_done_cycle", done_cyc, 14);
    chk("t6a_valid_count", n_valid, 12);
    run_frame(3, 3, 1'b0, 1'b0, 1'b0, 1'b1, done_cyc, last_cyc, n_valid, n_inner, first_valid);
    chk("t6b_done_cycle", done_cyc, 11);
    chk("t6b_last_cycle", last_cyc, 10);
    chk("t6b_valid_count", n_valid, 9);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
